// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light blocks: one-hot light codes,
// scheduler phase encoding and the per-approach light decode.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALLRED  = 2'b10,
        PH_INVALID = 2'b11
    } phase_t;

    // Every approach red except the holder, which shows green or yellow.
    function automatic logic [11:0] decode_lights(input phase_t ph, input logic [1:0] g);
        logic [11:0] l;
        l = {4{LIGHT_RED}};
        case (ph)
            PH_GREEN:  l[int'(g)*3 +: 3] = LIGHT_GREEN;
            PH_YELLOW: l[int'(g)*3 +: 3] = LIGHT_YELLOW;
            default:   l = {4{LIGHT_RED}};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_rr_pick.sv
// Round-robin successor search: first requester after cur (cur+1..cur+3, mod 4).
// The current holder itself is never picked.
module intersection_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] cur,
    output logic [1:0] pick,
    output logic       valid
);

    // Scan farthest first so the nearest requester overwrites and wins.
    always_comb begin
        pick  = cur;
        valid = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            if (req[cur + 2'(k)]) begin
                pick  = cur + 2'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Four-approach intersection scheduler: green/yellow/all-red sequencing with
// min/max green timers and round-robin hand-over of the crossing.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int CW        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  car,
    output logic [11:0] lights,
    output logic [1:0]  grant,
    output logic [1:0]  phase
);

    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW - 1);
    localparam logic [CW-1:0] R_LAST   = CW'(ALL_RED - 1);

    phase_t        state;
    logic [1:0]    nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    pick;
    logic          other_req;

    intersection_rr_pick u_pick (
        .req   (car),
        .cur   (grant),
        .pick  (pick),
        .valid (other_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PH_GREEN;
            grant <= 2'd0;
            nxt   <= 2'd0;
            cnt   <= '0;
        end else begin
            case (state)
                PH_GREEN: begin
                    // Yield once min green is served, if someone else waits and
                    // the holder has gone quiet or has used up its max green.
                    if (cnt >= MIN_LAST && other_req && (!car[grant] || cnt == MAX_LAST)) begin
                        state <= PH_YELLOW;
                        nxt   <= pick;
                        cnt   <= '0;
                    end else if (cnt != MAX_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (cnt == Y_LAST) begin
                        state <= PH_ALLRED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_ALLRED: begin
                    // Hand over even if the successor's car has left meanwhile.
                    if (cnt == R_LAST) begin
                        state <= PH_GREEN;
                        grant <= nxt;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= PH_GREEN;
                    grant <= 2'd0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Lights depend only on registered state; car never reaches them directly.
    assign lights = decode_lights(state, grant);
    assign phase  = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: a per-cycle vector table for a
// single hand-over plus hand-written rotation, alternation and reset sequences.
module tb_intersection_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  car;
    logic [11:0] lights;
    logic [1:0]  grant;
    logic [1:0]  phase;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [3:0]  car;
        logic [1:0]  phase;
        logic [1:0]  grant;
        logic [11:0] lights;
    } vec_t;

    vec_t vecs[8];

    intersection_scheduler dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .car    (car),
        .lights (lights),
        .grant  (grant),
        .phase  (phase)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected light word built independently of the RTL package.
    function automatic logic [11:0] exp_lights(input logic [1:0] ph, input logic [1:0] g);
        logic [11:0] l;
        l = 12'h924;
        if (ph == 2'b00) l[g*3 +: 3] = 3'b001;
        if (ph == 2'b01) l[g*3 +: 3] = 3'b010;
        return l;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {phase,grant,lights}=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] ph, input logic [1:0] g);
        check(name, {phase, grant, lights}, {ph, g, exp_lights(ph, g)});
    endtask

    // Advance one clock; return at the following negedge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for two edges, then release; outputs then show cycle 0.
    task automatic do_reset(input logic [3:0] c, input logic check_it);
        @(negedge clk);
        rst_n = 1'b0;
        car   = 4'b1111;
        repeat (2) begin
            tick();
            if (check_it) check_state("reset_hold", 2'b00, 2'b00);
        end
        rst_n = 1'b1;
        car   = c;
    endtask

    initial begin
        rst_n = 1'b0;
        car   = 4'b0000;

        // Test 1: reset with all cars present
        do_reset(4'b0001, 1'b1);

        // Test 2: only the holder requests, green holds indefinitely
        for (int c = 0; c < 30; c++) begin
            check_state("hold_alone", 2'b00, 2'b00);
            tick();
        end

        // Test 3: table-driven single hand-over 0 -> 1
        vecs[0] = '{4'b0010, 2'b00, 2'b00, 12'h921};
        vecs[1] = '{4'b0010, 2'b00, 2'b00, 12'h921};
        vecs[2] = '{4'b0010, 2'b00, 2'b00, 12'h921};
        vecs[3] = '{4'b0010, 2'b00, 2'b00, 12'h921};
        vecs[4] = '{4'b0010, 2'b01, 2'b00, 12'h922};
        vecs[5] = '{4'b0010, 2'b01, 2'b00, 12'h922};
        vecs[6] = '{4'b0010, 2'b10, 2'b00, 12'h924};
        vecs[7] = '{4'b0010, 2'b00, 2'b01, 12'h90C};
        do_reset(vecs[0].car, 1'b0);
        for (int i = 0; i < 8; i++) begin
            car = vecs[i].car;
            check($sformatf("handover_c%0d", i), {phase, grant, lights},
                  {vecs[i].phase, vecs[i].grant, vecs[i].lights});
            tick();
        end

        // Test 4: all approaches request; 8 green + 2 yellow + 1 all-red per slot
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset(4'b1111, 1'b0);
        for (int c = 0; c <= 44; c++) begin
            int p;
            logic [1:0] ph;
            logic [1:0] g;
            p  = c % 11;
            g  = 2'((c / 11) % 4);
            ph = (p < 8) ? 2'b00 : (p < 10) ? 2'b01 : 2'b10;
            check_state($sformatf("rotate_c%0d", c), ph, g);
            if (p == 0) begin
                logic [1:0] e;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rotate_queue: expected-grant queue empty at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rotate_grant_c%0d", c), {14'd0, grant}, {14'd0, e});
                end
            end
            tick();
        end

        // Test 5a: approaches 0 and 2 alternate; 1 and 3 stay red
        do_reset(4'b0101, 1'b0);
        for (int c = 0; c <= 23; c++) begin
            check($sformatf("alt_red13_c%0d", c), {4'd0, lights[11:9], lights[5:3], 6'd0},
                  {4'd0, 3'b100, 3'b100, 6'd0});
            if (c == 11) check_state("alt_grant2", 2'b00, 2'b10);
            if (c == 22) check_state("alt_grant0", 2'b00, 2'b00);
            tick();
        end

        // Test 5b: car[2] drops during yellow; 2 still gets min green
        do_reset(4'b0101, 1'b0);
        for (int c = 0; c <= 15; c++) begin
            if (c == 8) begin
                check_state("drop_yellow", 2'b01, 2'b00);
                car = 4'b0001;
            end
            if (c >= 11 && c <= 14) check_state($sformatf("drop_min_c%0d", c), 2'b00, 2'b10);
            if (c == 15) check_state("drop_yield", 2'b01, 2'b10);
            tick();
        end

        // Test 6: reset pulse during yellow of 0 -> 1
        do_reset(4'b0010, 1'b0);
        for (int c = 0; c <= 9; c++) begin
            if (c == 4) begin
                check_state("mid_yellow", 2'b01, 2'b00);
                rst_n = 1'b0;
            end
            if (c == 5) rst_n = 1'b1;
            if (c >= 5 && c <= 8) check_state($sformatf("post_rst_c%0d", c), 2'b00, 2'b00);
            if (c == 9) check_state("post_rst_yellow", 2'b01, 2'b00);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
